// File: rtl/munoc_bresp_merger_pkg.sv
// Shared definitions for the NoC write-response merger: AXI B-channel
// response encodings and the merge-priority helpers.
package munoc_bresp_merger_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_e;

  function automatic logic resp_is_err(input resp_e r);
    return (r == RESP_SLVERR) || (r == RESP_DECERR);
  endfunction

  // An error already folded in wins; otherwise the newest response replaces
  // the running value, so a later OKAY overrides an earlier EXOKAY.
  function automatic resp_e merge_resp(input resp_e acc, input resp_e cur);
    return resp_is_err(acc) ? acc : cur;
  endfunction

endpackage

// File: rtl/munoc_bresp_merger_fifo.sv
// Small synchronous FIFO holding per-transaction routing contexts.
// The head entry is presented combinationally on rdata.
module munoc_bresp_merger_fifo #(
  parameter int BW_DATA = 20,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [BW_DATA-1:0] wdata,
  output logic [BW_DATA-1:0] rdata,
  output logic               empty,
  output logic               full
);

  localparam int BW_PTR = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW_CNT = $clog2(DEPTH + 1);

  logic [BW_DATA-1:0] mem_r [DEPTH];
  logic [BW_PTR-1:0]  wptr_r;
  logic [BW_PTR-1:0]  rptr_r;
  logic [BW_CNT-1:0]  count_r;
  logic               empty_s;
  logic               full_s;
  logic               wr_en_s;
  logic               rd_en_s;

  function automatic logic [BW_PTR-1:0] ptr_inc(input logic [BW_PTR-1:0] p);
    return (p == BW_PTR'(DEPTH - 1)) ? {BW_PTR{1'b0}} : p + {{(BW_PTR-1){1'b0}}, 1'b1};
  endfunction

  assign empty_s = (count_r == {BW_CNT{1'b0}});
  assign full_s  = (count_r == BW_CNT'(DEPTH));
  assign rd_en_s = pop && !empty_s;
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign wr_en_s = push && (!full_s || rd_en_s);

  assign rdata = mem_r[rptr_r];
  assign empty = empty_s;
  assign full  = full_s;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r  <= {BW_PTR{1'b0}};
      rptr_r  <= {BW_PTR{1'b0}};
      count_r <= {BW_CNT{1'b0}};
    end else begin
      if (wr_en_s) wptr_r <= ptr_inc(wptr_r);
      if (rd_en_s) rptr_r <= ptr_inc(rptr_r);
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + {{(BW_CNT-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(BW_CNT-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Context storage.
  always_ff @(posedge clk) begin
    if (wr_en_s) mem_r[wptr_r] <= wdata;
  end

endmodule

// File: rtl/munoc_bresp_merger.sv
// Folds the N sub-responses of a split write into one B response per context.
// Optional feature: MUNOC_BRESP_MERGE_ERRCNT_EN enables the saturating err_count.
module munoc_bresp_merger
  import munoc_bresp_merger_pkg::*;
#(
  parameter int BW_NODE_ID = 4,
  parameter int BW_TID     = 8,
  parameter int BW_CNT     = 8,
  parameter int CTX_DEPTH  = 4,
  parameter int CTX_ID_SRC = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 ctx_valid,
  output logic                                 ctx_ready,
  input  logic [BW_NODE_ID+BW_TID+BW_CNT-1:0]  ctx_data,
  input  logic                                 s_bvalid,
  output logic                                 s_bready,
  input  logic [BW_NODE_ID+BW_TID-1:0]         s_bid,
  input  logic [1:0]                           s_bresp,
  output logic                                 m_bvalid,
  input  logic                                 m_bready,
  output logic [BW_NODE_ID+BW_TID+2-1:0]       m_bdata,
  output logic [15:0]                          err_count,
  input  logic                                 err_clear
);

  localparam int BW_ID  = BW_NODE_ID + BW_TID;
  localparam int BW_CTX = BW_ID + BW_CNT;
  localparam int BW_MB  = BW_ID + 2;

  logic [BW_CTX-1:0] ctx_head_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;
  logic [BW_ID-1:0]  head_id_s;
  logic [BW_CNT-1:0] head_nm1_s;
  logic              is_final_s;
  logic              s_bready_s;
  logic              s_accept_s;
  logic              pop_s;
  logic              push_s;
  resp_e             merged_s;
  logic [BW_ID-1:0]  out_id_s;

  logic [BW_CNT-1:0] sub_cnt_r;
  resp_e             acc_resp_r;
  logic              m_bvalid_r;
  logic [BW_MB-1:0]  m_bdata_r;

  assign head_id_s  = ctx_head_s[BW_CTX-1:BW_CNT];
  assign head_nm1_s = ctx_head_s[BW_CNT-1:0];
  assign is_final_s = (sub_cnt_r == head_nm1_s);

  // Non-final beats never touch the output slot, so only a final one stalls.
  assign s_bready_s = !fifo_empty_s && (!is_final_s || !m_bvalid_r || m_bready);
  assign s_accept_s = s_bvalid && s_bready_s;
  assign pop_s      = s_accept_s && is_final_s;
  assign ctx_ready  = !fifo_full_s || pop_s;
  assign push_s     = ctx_valid && ctx_ready;
  assign merged_s   = merge_resp(acc_resp_r, resp_e'(s_bresp));

  munoc_bresp_merger_fifo #(
    .BW_DATA (BW_CTX),
    .DEPTH   (CTX_DEPTH)
  ) u_ctx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (ctx_data),
    .rdata (ctx_head_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s)
  );

  // Output ID source selection.
  always_comb begin
    out_id_s = head_id_s;
    if (CTX_ID_SRC != 0) begin
      out_id_s = head_id_s;
    end else begin
      out_id_s = s_bid;
    end
  end

  // Sub-response counter and running merged response of the head transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      sub_cnt_r  <= {BW_CNT{1'b0}};
      acc_resp_r <= RESP_OKAY;
    end else if (s_accept_s) begin
      if (is_final_s) begin
        sub_cnt_r  <= {BW_CNT{1'b0}};
        acc_resp_r <= RESP_OKAY;
      end else begin
        sub_cnt_r  <= sub_cnt_r + {{(BW_CNT-1){1'b0}}, 1'b1};
        acc_resp_r <= merged_s;
      end
    end
  end

  // Merged-response output slot; a load may coincide with a drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_bvalid_r <= 1'b0;
      m_bdata_r  <= {BW_MB{1'b0}};
    end else if (pop_s) begin
      m_bvalid_r <= 1'b1;
      m_bdata_r  <= {out_id_s, merged_s};
    end else if (m_bready) begin
      m_bvalid_r <= 1'b0;
    end
  end

  assign s_bready = s_bready_s;
  assign m_bvalid = m_bvalid_r;
  assign m_bdata  = m_bdata_r;

`ifdef MUNOC_BRESP_MERGE_ERRCNT_EN
  logic [15:0] err_count_r;

  // Saturating count of error responses delivered to the network.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_r <= 16'h0000;
    end else if (err_clear) begin
      err_count_r <= 16'h0000;
    end else if (m_bvalid_r && m_bready && resp_is_err(resp_e'(m_bdata_r[1:0]))
                 && (err_count_r != 16'hFFFF)) begin
      err_count_r <= err_count_r + 16'h0001;
    end
  end

  assign err_count = err_count_r;
`else
  logic err_clear_unused_s;

  assign err_clear_unused_s = err_clear;
  assign err_count          = 16'h0000;
`endif

endmodule

// File: tb/tb_munoc_bresp_merger.sv
// Scoreboard bench for munoc_bresp_merger (default parameters, context ID source).
module tb_munoc_bresp_merger;

  logic        clk = 1'b0;
  logic        rst;
  logic        ctx_valid;
  logic        ctx_ready;
  logic [19:0] ctx_data;
  logic        s_bvalid;
  logic        s_bready;
  logic [11:0] s_bid;
  logic [1:0]  s_bresp;
  logic        m_bvalid;
  logic        m_bready;
  logic [13:0] m_bdata;
  logic [15:0] err_count;
  logic        err_clear;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_pushed = 0;
  int          n_out    = 0;
  logic [13:0] sb_q[$];

  localparam logic [1:0] OKAY = 2'd0, EXOKAY = 2'd1, SLVERR = 2'd2, DECERR = 2'd3;

  always #5 clk = ~clk;

  munoc_bresp_merger dut (
    .clk       (clk),
    .rst       (rst),
    .ctx_valid (ctx_valid),
    .ctx_ready (ctx_ready),
    .ctx_data  (ctx_data),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .s_bid     (s_bid),
    .s_bresp   (s_bresp),
    .m_bvalid  (m_bvalid),
    .m_bready  (m_bready),
    .m_bdata   (m_bdata),
    .err_count (err_count),
    .err_clear (err_clear)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic [3:0] node, input logic [7:0] tid, input logic [1:0] resp);
    sb_q.push_back({node, tid, resp});
    n_pushed++;
  endtask

  // Output monitor: every accepted merged response is compared with the queue head.
  always @(negedge clk) begin
    if (!rst && m_bvalid === 1'b1 && m_bready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("m_bdata_unexpected", 32'(m_bdata), 32'hFFFF_FFFF);
      end else begin
        check("m_bdata", 32'(m_bdata), 32'(sb_q.pop_front()));
        n_out++;
      end
    end
  end

  task automatic push_ctx(input logic [3:0] node, input logic [7:0] tid, input logic [7:0] nm1,
                          input logic [1:0] exp_resp, input bit track);
    int t;
    @(posedge clk); #1;
    ctx_valid = 1'b1;
    ctx_data  = {node, tid, nm1};
    @(negedge clk);
    t = 0;
    while (!ctx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!ctx_ready) check("ctx_push_timeout", 32'(ctx_ready), 32'd1);
    else if (track) sb_push(node, tid, exp_resp);
    @(posedge clk); #1;
    ctx_valid = 1'b0;
  endtask

  task automatic send_resp(input logic [1:0] resp, input bit must);
    int t;
    @(posedge clk); #1;
    s_bvalid = 1'b1;
    s_bresp  = resp;
    s_bid    = 12'($urandom);
    @(negedge clk);
    if (must) check("s_bready_accept", 32'(s_bready), 32'd1);
    t = 0;
    while (!s_bready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!s_bready) check("s_bready_timeout", 32'(s_bready), 32'd1);
    @(posedge clk); #1;
    s_bvalid = 1'b0;
  endtask

  initial begin
    logic [1:0] r [5];
    int t;
    rst = 1'b1; ctx_valid = 1'b0; ctx_data = 20'h0; s_bvalid = 1'b0; s_bid = 12'h0;
    s_bresp = OKAY; m_bready = 1'b1; err_clear = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctx_ready", 32'(ctx_ready), 32'd1);
    check("rst_s_bready", 32'(s_bready), 32'd0);
    check("rst_m_bvalid", 32'(m_bvalid), 32'd0);
    check("rst_m_bdata", 32'(m_bdata), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single response; push and response together: response waits one cycle.
    @(posedge clk); #1;
    ctx_valid = 1'b1; ctx_data = {4'd3, 8'h5A, 8'd0};
    s_bvalid = 1'b1; s_bresp = OKAY; s_bid = 12'hFFF;
    @(negedge clk);
    check("s_bready_on_push", 32'(s_bready), 32'd0);
    check("ctx_ready_empty", 32'(ctx_ready), 32'd1);
    sb_push(4'd3, 8'h5A, OKAY);
    @(posedge clk); #1;
    ctx_valid = 1'b0;
    @(negedge clk);
    check("s_bready_head", 32'(s_bready), 32'd1);
    @(posedge clk); #1;
    s_bvalid = 1'b0;
    @(negedge clk);
    check("m_bvalid_latency", 32'(m_bvalid), 32'd1);
    @(negedge clk);
    check("m_bvalid_drained", 32'(m_bvalid), 32'd0);

    // Merge priority cases.
    push_ctx(4'd4, 8'hA5, 8'd3, SLVERR, 1'b1);
    send_resp(OKAY, 1'b1); send_resp(SLVERR, 1'b1); send_resp(DECERR, 1'b1); send_resp(OKAY, 1'b1);
    push_ctx(4'd8, 8'h81, 8'd1, OKAY, 1'b1);
    send_resp(EXOKAY, 1'b1); send_resp(OKAY, 1'b1);
    push_ctx(4'd9, 8'h92, 8'd1, EXOKAY, 1'b1);
    send_resp(OKAY, 1'b1); send_resp(EXOKAY, 1'b1);
    push_ctx(4'd10, 8'hA3, 8'd2, DECERR, 1'b1);
    send_resp(OKAY, 1'b1); send_resp(DECERR, 1'b1); send_resp(SLVERR, 1'b1);
    push_ctx(4'd11, 8'hB4, 8'd0, EXOKAY, 1'b1);
    send_resp(EXOKAY, 1'b1);
    // Largest transaction: 256 sub-responses.
    push_ctx(4'd12, 8'hC5, 8'd255, EXOKAY, 1'b1);
    for (int i = 0; i < 256; i++) send_resp((i == 255) ? EXOKAY : OKAY, 1'b0);

    // Fill the FIFO, then drain five finals back to back.
    r[0] = OKAY; r[1] = SLVERR; r[2] = EXOKAY; r[3] = DECERR; r[4] = OKAY;
    for (int i = 0; i < 4; i++) push_ctx(4'(i + 1), 8'(8'h10 + i), 8'd0, r[i], 1'b1);
    @(posedge clk); #1;
    ctx_valid = 1'b1; ctx_data = {4'd0, 8'hF0, 8'd0};
    @(negedge clk);
    check("ctx_ready_full", 32'(ctx_ready), 32'd0);
    @(posedge clk); #1;
    s_bvalid = 1'b1; s_bresp = r[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("s_bready_stream", 32'(s_bready), 32'd1);
      if (i == 0) begin
        check("ctx_ready_pop", 32'(ctx_ready), 32'd1);
        if (ctx_ready) sb_push(4'd0, 8'hF0, r[4]);
      end else begin
        check("m_bvalid_no_bubble", 32'(m_bvalid), 32'd1);
      end
      @(posedge clk); #1;
      if (i == 0) ctx_valid = 1'b0;
      if (i < 4) s_bresp = r[i + 1];
      else s_bvalid = 1'b0;
    end
    @(negedge clk);
    check("m_bvalid_last", 32'(m_bvalid), 32'd1);
    repeat (2) @(posedge clk);

    // Backpressure: pending output stalls only the next final.
    #1 m_bready = 1'b0;
    push_ctx(4'd1, 8'h11, 8'd0, EXOKAY, 1'b1);
    send_resp(EXOKAY, 1'b1);
    push_ctx(4'd2, 8'h22, 8'd2, DECERR, 1'b1);
    send_resp(OKAY, 1'b1);
    send_resp(DECERR, 1'b1);
    @(posedge clk); #1;
    s_bvalid = 1'b1; s_bresp = SLVERR;
    repeat (10) begin
      @(negedge clk);
      check("s_bready_stall", 32'(s_bready), 32'd0);
      check("m_bvalid_hold", 32'(m_bvalid), 32'd1);
      check("m_bdata_stable", 32'(m_bdata), 32'({4'd1, 8'h11, EXOKAY}));
      @(posedge clk); #1;
    end
    m_bready = 1'b1;
    @(negedge clk);
    check("s_bready_bypass", 32'(s_bready), 32'd1);
    @(posedge clk); #1;
    s_bvalid = 1'b0;
    @(negedge clk);
    check("m_bvalid_reload", 32'(m_bvalid), 32'd1);
    repeat (2) @(posedge clk);

    // Reset mid-transaction with an output pending.
    #1 m_bready = 1'b0;
    push_ctx(4'd5, 8'h55, 8'd0, SLVERR, 1'b0);
    send_resp(SLVERR, 1'b1);
    push_ctx(4'd6, 8'h66, 8'd3, SLVERR, 1'b0);
    send_resp(SLVERR, 1'b1);
    send_resp(DECERR, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_m_bvalid", 32'(m_bvalid), 32'd0);
    check("rst_mid_ctx_ready", 32'(ctx_ready), 32'd1);
    check("rst_mid_s_bready", 32'(s_bready), 32'd0);
    @(posedge clk); #1;
    m_bready = 1'b1;
    push_ctx(4'd7, 8'h77, 8'd0, OKAY, 1'b1);
    send_resp(OKAY, 1'b1);
    @(negedge clk);
    check("m_bvalid_after_rst", 32'(m_bvalid), 32'd1);

    // Error counter.
    push_ctx(4'd1, 8'hE1, 8'd0, SLVERR, 1'b1); send_resp(SLVERR, 1'b1);
    push_ctx(4'd2, 8'hE2, 8'd0, DECERR, 1'b1); send_resp(DECERR, 1'b1);
    push_ctx(4'd3, 8'hE3, 8'd0, SLVERR, 1'b1); send_resp(SLVERR, 1'b1);
    repeat (2) @(negedge clk);
`ifdef MUNOC_BRESP_MERGE_ERRCNT_EN
    check("err_count_three", 32'(err_count), 32'd3);
`else
    check("err_count_tied", 32'(err_count), 32'd0);
`endif
    @(posedge clk); #1;
    m_bready = 1'b0;
    push_ctx(4'd4, 8'hE4, 8'd0, DECERR, 1'b1);
    send_resp(DECERR, 1'b1);
    @(posedge clk); #1;
    m_bready = 1'b1; err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    @(negedge clk);
    check("err_count_clear", 32'(err_count), 32'd0);

    t = 0;
    while (sb_q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    check("out_count", 32'(n_out), 32'(n_pushed));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
